bram_word_serializer: RTL and testbench
=======================================

Name: bram_word_serializer

Overview:
- Parametrised successor to the 4-bit BRAM-fed shift-register test path. The block autonomously walks a block-RAM address range, fetches each word and shifts it out serially.
- Output stream is gapless, with MSB- or LSB-first order, optional continuous looping and a stop request.
- Sits between a single-port read-only BRAM (1-cycle synchronous read) and a serial consumer. Control inputs come from VIO/sync logic and status goes to ILA triggers.

Parameters:
- WIDTH, 4, bits per BRAM word; must be >= 2 (required for the gapless prefetch).
- ADDR_W, 2, BRAM address width.
- DEPTH, 4, number of words per pass; 1..2**ADDR_W; words at addresses 0..DEPTH-1.
- LSB_FIRST, 0, 0 = shift MSB first, 1 = shift LSB first.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle request to begin a pass; ignored unless idle.
- loop  in  1  sampled at each word load; 1 = wrap from DEPTH-1 to 0 instead of finishing.
- stop  in  1  pulse; current word completes, then the block returns to idle.
- mem_addr  out  ADDR_W  registered BRAM address.
- mem_dout  in  WIDTH  BRAM read data.
- ser_out  out  1  serial data bit.
- ser_valid  out  1  ser_out is a valid bit this cycle.
- word_start  out  1  high on the first bit of each word.
- word_idx  out  ADDR_W  address of the word currently being shifted.
- busy  out  1  not idle.
- done  out  1  one-cycle pulse when a pass ends, by completion or by stop.

Behaviour:
- Reset (async, any state):
  - Goes to IDLE.
  - mem_addr, word_idx, shift reg, bit counter = 0.
  - ser_out, ser_valid, word_start, busy, done = 0.
  - Pending stop flag cleared.
  - Takes effect immediately, mid-word included; there is no flush.
- BRAM timing contract: the BRAM samples mem_addr at edge e and mem_dout is valid for capture at edge e+1. A mem_addr update at edge k therefore yields data capturable at edge k+2.
- FSM states: IDLE, FETCH, SHIFT.
- IDLE:
  - busy=0, ser_valid=0, mem_addr held at 0.
  - start=1 -> FETCH with fetch-wait counter = 0.
- FETCH:
  - Waits 2 edges after leaving IDLE, then loads shift reg <= mem_dout (word 0).
  - Same edge: word_idx <= 0, mem_addr <= next address, bit_cnt <= 0, -> SHIFT.
  - Timing: start sampled at edge 0, first valid bit after edge 2.
- SHIFT:
  - ser_valid=1.
  - ser_out = shift reg[WIDTH-1] when LSB_FIRST=0, else shift reg[0].
  - Each edge: shift by one and bit_cnt++.
  - word_start=1 when bit_cnt==0.
- Word boundary (edge where bit_cnt==WIDTH-1):
  - If stop pending, or word_idx==DEPTH-1 with loop=0: -> IDLE, done=1 for one cycle, ser_valid=0 next cycle, mem_addr<=0.
  - Otherwise: load next word from mem_dout, word_idx <= mem_addr, mem_addr <= next, bit_cnt <= 0. No bubble between words.
- Next-address rule:
  - DEPTH-1 -> 0 when loop=1, sampled at that load.
  - Otherwise addr+1, held (not wrapped) after the last word.
  - Wrap is explicit; it does not rely on 2**ADDR_W overflow.
- stop handling:
  - Latched into a pending flag in SHIFT/FETCH; ignored in IDLE.
  - stop in FETCH: word 0 is still shifted in full, then the pass ends.
  - stop on the same edge as a word-boundary load takes effect at the end of the newly loaded word.
- start while busy: ignored.
- start and stop in the same IDLE cycle: start wins; stop is ignored because the block is in IDLE.
- DEPTH=1: every load is address 0. With loop=1, the same word repeats gaplessly.
- Throughput: exactly WIDTH valid bits per word, DEPTH*WIDTH valid bits per non-loop pass, with ser_valid continuous across the pass.

Decomposition:
- Shared package: FSM state encoding (IDLE/FETCH/SHIFT, 2-bit) and a clog2 helper for the bit-counter width.
- One natural sub-module: piso_shift, a parallel-load shift register with WIDTH, LSB_FIRST, load, shift and async rst. It generalises the existing sr block and is reused here.

Test Plan:
- Pass 1: WIDTH=4, DEPTH=4, LSB_FIRST=0, BRAM {0xA,0x3,0xF,0x0}, start pulse at edge 0.
  - First ser_valid after edge 2.
  - Serial sequence 1010_0011_1111_0000 over 16 contiguous cycles.
  - word_start on bits 0/4/8/12; word_idx 0,1,2,3.
  - done pulse the cycle after bit 15; busy then falls.
- Pass 2: same setup with LSB_FIRST=1 -> 0101_1100_1111_0000.
- Pass 3: loop=1 held -> after word 3, word 0 (0xA) follows with no gap and mem_addr wraps 3->0. Then pulse stop during word 1 of the second lap -> that word (0x3) completes, done=1, then IDLE.
- Pass 4: assert rst mid-word (bit 2 of word 1) -> all outputs 0 immediately, without waiting for an edge. A subsequent start gives a clean restart from word 0, first bit 2 edges later.
- Pass 5: start pulses while busy and stop while idle -> no effect on sequence or timing. DEPTH=1 with loop=1 -> word 0 repeats continuously with word_start every WIDTH cycles.

Source files
------------

// File: rtl/bram_word_serializer_pkg.sv
// Shared definitions for the BRAM word serializer: FSM encoding and a
// constant-evaluable ceil(log2) used to size the bit counter.
package bram_word_serializer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2
  } state_e;

  function automatic int ws_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bram_word_serializer_piso_shift.sv
// Parallel-in serial-out shift register with selectable bit order.
// Load has priority over shift; vacated positions fill with zero.
module bram_word_serializer_piso_shift #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             ser_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Next shift-register contents
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = din_i;
    end else if (shift_i) begin
      if (LSB_FIRST) begin
        sr_d = {1'b0, sr_q[WIDTH-1:1]};
      end else begin
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      sr_d = sr_q;
    end
  end

  // Shift-register state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= {WIDTH{1'b0}};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser_o = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];

endmodule

// File: rtl/bram_word_serializer.sv
// Walks BRAM addresses 0..DEPTH-1, prefetching one word ahead so the serial
// stream stays gapless across word boundaries, with optional looping and stop.
module bram_word_serializer
  import bram_word_serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ADDR_W    = 2,
  parameter int DEPTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              loop_i,
  input  logic              stop_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [WIDTH-1:0]  mem_dout_i,
  output logic              ser_out_o,
  output logic              ser_valid_o,
  output logic              word_start_o,
  output logic [ADDR_W-1:0] word_idx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = (ws_clog2(WIDTH) < 1) ? 1 : ws_clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic              fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic              stop_pend_q, stop_pend_d;
  logic              ser_valid_q, ser_valid_d;
  logic              word_start_q, word_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load_s;
  logic              shift_s;

  // The wrap is explicit so DEPTH need not be a power of two
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic lp);
    if (addr == ADDR_LAST) begin
      return lp ? {ADDR_W{1'b0}} : addr;
    end else begin
      return addr + ADDR_W'(1);
    end
  endfunction

  // Next-state, datapath control and registered-output decode
  always_comb begin
    state_d     = state_q;
    fetch_cnt_d = fetch_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    mem_addr_d  = mem_addr_q;
    word_idx_d  = word_idx_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    load_s      = 1'b0;
    shift_s     = 1'b0;

    case (state_q)
      S_IDLE: begin
        mem_addr_d  = {ADDR_W{1'b0}};
        stop_pend_d = 1'b0;
        if (start_i) begin
          state_d     = S_FETCH;
          fetch_cnt_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        stop_pend_d = stop_pend_q | stop_i;
        if (fetch_cnt_q) begin
          load_s     = 1'b1;
          word_idx_d = {ADDR_W{1'b0}};
          mem_addr_d = next_addr(mem_addr_q, loop_i);
          bit_cnt_d  = {CNT_W{1'b0}};
          state_d    = S_SHIFT;
        end else begin
          fetch_cnt_d = 1'b1;
        end
      end

      S_SHIFT: begin
        if (bit_cnt_q == CNT_LAST) begin
          if (stop_pend_q || ((word_idx_q == ADDR_LAST) && !loop_i)) begin
            shift_s     = 1'b1;
            state_d     = S_IDLE;
            done_d      = 1'b1;
            mem_addr_d  = {ADDR_W{1'b0}};
            bit_cnt_d   = {CNT_W{1'b0}};
            stop_pend_d = 1'b0;
          end else begin
            // A stop arriving on this load applies to the word being loaded
            load_s      = 1'b1;
            word_idx_d  = mem_addr_q;
            mem_addr_d  = next_addr(mem_addr_q, loop_i);
            bit_cnt_d   = {CNT_W{1'b0}};
            stop_pend_d = stop_i;
          end
        end else begin
          shift_s     = 1'b1;
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
          stop_pend_d = stop_pend_q | stop_i;
        end
      end

      default: begin
        state_d     = S_IDLE;
        mem_addr_d  = {ADDR_W{1'b0}};
        bit_cnt_d   = {CNT_W{1'b0}};
        stop_pend_d = 1'b0;
      end
    endcase

    ser_valid_d  = (state_d == S_SHIFT);
    word_start_d = (state_d == S_SHIFT) && (bit_cnt_d == {CNT_W{1'b0}});
    busy_d       = (state_d != S_IDLE);
  end

  // Control and status registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      fetch_cnt_q  <= 1'b0;
      bit_cnt_q    <= {CNT_W{1'b0}};
      mem_addr_q   <= {ADDR_W{1'b0}};
      word_idx_q   <= {ADDR_W{1'b0}};
      stop_pend_q  <= 1'b0;
      ser_valid_q  <= 1'b0;
      word_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_cnt_q  <= fetch_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      mem_addr_q   <= mem_addr_d;
      word_idx_q   <= word_idx_d;
      stop_pend_q  <= stop_pend_d;
      ser_valid_q  <= ser_valid_d;
      word_start_q <= word_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  bram_word_serializer_piso_shift #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_piso_shift (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load_s),
    .shift_i (shift_s),
    .din_i   (mem_dout_i),
    .ser_o   (ser_out_o)
  );

  assign mem_addr_o   = mem_addr_q;
  assign word_idx_o   = word_idx_q;
  assign ser_valid_o  = ser_valid_q;
  assign word_start_o = word_start_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_bram_word_serializer.sv
// Directed bench: MSB-first and LSB-first 4-word instances share controls;
// a DEPTH=1 instance has its own controls for the repeat-word case.
module tb_bram_word_serializer;

  logic clk;
  logic rst;
  logic start, loop, stop;
  logic start_d, loop_d, stop_d;

  logic [1:0] mem_addr_m, word_idx_m, mem_addr_l, word_idx_l;
  logic [3:0] mem_dout_m, mem_dout_l, mem_dout_d;
  logic       ser_out_m, ser_valid_m, word_start_m, busy_m, done_m;
  logic       ser_out_l, ser_valid_l, word_start_l, busy_l, done_l;
  logic [0:0] mem_addr_d, word_idx_d;
  logic       ser_out_d, ser_valid_d, word_start_d, busy_d, done_d;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_msb = 16'hA3F0;  // 1010_0011_1111_0000
  logic [15:0] exp_lsb = 16'h5CF0;  // 0101_1100_1111_0000
  logic [3:0]  exp_d1  = 4'h6;      // 0110

  function automatic logic [3:0] rom4(input logic [1:0] a);
    case (a)
      2'd0:    return 4'hA;
      2'd1:    return 4'h3;
      2'd2:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  bram_word_serializer #(.WIDTH(4), .ADDR_W(2), .DEPTH(4), .LSB_FIRST(1'b0)) dut_m (
    .clk_i(clk), .rst_i(rst), .start_i(start), .loop_i(loop), .stop_i(stop),
    .mem_addr_o(mem_addr_m), .mem_dout_i(mem_dout_m), .ser_out_o(ser_out_m),
    .ser_valid_o(ser_valid_m), .word_start_o(word_start_m), .word_idx_o(word_idx_m),
    .busy_o(busy_m), .done_o(done_m));

  bram_word_serializer #(.WIDTH(4), .ADDR_W(2), .DEPTH(4), .LSB_FIRST(1'b1)) dut_l (
    .clk_i(clk), .rst_i(rst), .start_i(start), .loop_i(loop), .stop_i(stop),
    .mem_addr_o(mem_addr_l), .mem_dout_i(mem_dout_l), .ser_out_o(ser_out_l),
    .ser_valid_o(ser_valid_l), .word_start_o(word_start_l), .word_idx_o(word_idx_l),
    .busy_o(busy_l), .done_o(done_l));

  bram_word_serializer #(.WIDTH(4), .ADDR_W(1), .DEPTH(1), .LSB_FIRST(1'b0)) dut_d (
    .clk_i(clk), .rst_i(rst), .start_i(start_d), .loop_i(loop_d), .stop_i(stop_d),
    .mem_addr_o(mem_addr_d), .mem_dout_i(mem_dout_d), .ser_out_o(ser_out_d),
    .ser_valid_o(ser_valid_d), .word_start_o(word_start_d), .word_idx_o(word_idx_d),
    .busy_o(busy_d), .done_o(done_d));

  // Synchronous-read BRAM models; address 1 of the small one must never be read
  always_ff @(posedge clk) begin
    mem_dout_m <= rom4(mem_addr_m);
    mem_dout_l <= rom4(mem_addr_l);
    mem_dout_d <= mem_addr_d[0] ? 4'hF : 4'h6;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One non-loop 4-word pass on both shared instances; noise adds idle stop
  // pulses and start pulses while busy, none of which may alter the stream.
  task automatic do_pass(input string tag, input bit noise);
    if (noise) begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
    end
    start = 1'b1;
    stop  = noise;
    tick();  // edge 0
    start = 1'b0;
    stop  = 1'b0;
    check($sformatf("%s_busy_e0", tag), busy_m, 1);
    check($sformatf("%s_valid_e0", tag), ser_valid_m, 0);
    tick();
    check($sformatf("%s_valid_e1", tag), ser_valid_m, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("%s_valid%0d", tag, i), ser_valid_m, 1);
      check($sformatf("%s_msb%0d", tag, i), ser_out_m, exp_msb[15-i]);
      check($sformatf("%s_lsb%0d", tag, i), ser_out_l, exp_lsb[15-i]);
      check($sformatf("%s_ws%0d", tag, i), word_start_m, (i % 4 == 0) ? 1 : 0);
      check($sformatf("%s_wsl%0d", tag, i), word_start_l, (i % 4 == 0) ? 1 : 0);
      check($sformatf("%s_idx%0d", tag, i), word_idx_m, i / 4);
      check($sformatf("%s_idxl%0d", tag, i), word_idx_l, i / 4);
      if (i % 4 == 0) begin
        check($sformatf("%s_addr%0d", tag, i), mem_addr_m, (i < 12) ? (i / 4 + 1) : 3);
      end
      start = noise && (i == 3 || i == 9 || i == 15);
    end
    tick();
    start = 1'b0;
    check($sformatf("%s_done", tag), done_m, 1);
    check($sformatf("%s_donel", tag), done_l, 1);
    check($sformatf("%s_busy_end", tag), busy_m, 0);
    check($sformatf("%s_busyl_end", tag), busy_l, 0);
    check($sformatf("%s_valid_end", tag), ser_valid_m, 0);
    check($sformatf("%s_addr_end", tag), mem_addr_m, 0);
    tick();
    check($sformatf("%s_done_pulse", tag), done_m, 0);
    check($sformatf("%s_idle", tag), busy_m, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; loop = 1'b0; stop = 1'b0;
    start_d = 1'b0; loop_d = 1'b0; stop_d = 1'b0;
    #12;
    check("rst_busy", busy_m, 0);
    check("rst_valid", ser_valid_m, 0);
    check("rst_ser", ser_out_m, 0);
    check("rst_addr", mem_addr_m, 0);
    check("rst_done", done_m, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy_m, 0);

    // Passes 1 and 2: MSB-first and LSB-first in parallel
    do_pass("p1", 1'b0);

    // Pass 3: loop held, wrap 3->0, stop during word 1 of the second lap
    loop  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 24; i++) begin
      tick();
      check($sformatf("p3_valid%0d", i), ser_valid_m, 1);
      check($sformatf("p3_ser%0d", i), ser_out_m, exp_msb[15-(i%16)]);
      check($sformatf("p3_idx%0d", i), word_idx_m, (i / 4) % 4);
      check($sformatf("p3_ws%0d", i), word_start_m, (i % 4 == 0) ? 1 : 0);
      if (i == 12) check("p3_wrap_addr", mem_addr_m, 0);
      if (i == 16) check("p3_lap2_addr", mem_addr_m, 1);
      stop = (i == 21);
    end
    tick();
    check("p3_done", done_m, 1);
    check("p3_busy", busy_m, 0);
    check("p3_valid", ser_valid_m, 0);
    loop = 1'b0;
    tick();

    // Pass 4: asynchronous reset at bit 2 of word 1, then clean restart
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("p4_ser%0d", i), ser_out_m, exp_msb[15-i]);
    end
    check("p4_pre_busy", busy_m, 1);
    #3 rst = 1'b1;
    #1;
    check("p4_rst_ser", ser_out_m, 0);
    check("p4_rst_valid", ser_valid_m, 0);
    check("p4_rst_ws", word_start_m, 0);
    check("p4_rst_busy", busy_m, 0);
    check("p4_rst_done", done_m, 0);
    check("p4_rst_addr", mem_addr_m, 0);
    check("p4_rst_idx", word_idx_m, 0);
    #1 rst = 1'b0;
    do_pass("p4r", 1'b0);

    // Pass 5a: stop while idle, start+stop in idle, starts while busy
    do_pass("p5", 1'b1);

    // Pass 5b: DEPTH=1 looping repeats word 0 gaplessly
    start_d = 1'b1;
    loop_d  = 1'b1;
    tick();
    start_d = 1'b0;
    tick();
    check("d1_valid_e1", ser_valid_d, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("d1_valid%0d", i), ser_valid_d, 1);
      check($sformatf("d1_ser%0d", i), ser_out_d, exp_d1[3-(i%4)]);
      check($sformatf("d1_ws%0d", i), word_start_d, (i % 4 == 0) ? 1 : 0);
      check($sformatf("d1_idx%0d", i), word_idx_d, 0);
      check($sformatf("d1_addr%0d", i), mem_addr_d, 0);
    end
    loop_d = 1'b0;
    tick();
    check("d1_done", done_d, 1);
    check("d1_busy", busy_d, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
